// File: rtl/nibble_serial_add_seq.sv
// Sequencer that adds two WIDTH-bit operands one nibble per cycle through an external 4-bit adder.
// Optional registered signed-overflow flag `ovf` is enabled by defining NIBBLE_ADD_OVERFLOW_EN.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c0,
  input  logic [3:0]       add_s,
  input  logic             add_c4,
`ifdef NIBBLE_ADD_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             cout_r, in_ready_r, busy_r, out_valid_r;
  logic             accept_s, done_s, release_s;

  function automatic logic [3:0] nib_sel(input logic [WIDTH-1:0] v, input logic [IW-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (i == IW'(n)) begin
        r = v[4*n +: 4];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state decode and adder drive; the adder sees zeros outside RUN.
  always_comb begin
    state_s   = state_r;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_c0    = 1'b0;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        add_a  = nib_sel(a_r, idx_r);
        add_b  = nib_sel(b_r, idx_r);
        add_c0 = carry_r;
        if (idx_r == LAST) begin
          done_s  = 1'b1;
          state_s = HOLD;
        end else begin
          state_s = RUN;
        end
      end
      HOLD: begin
        if (out_valid_r && out_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s == RUN);
      out_valid_r <= (state_s == HOLD);
    end
  end

  // Operand capture, per-nibble result accumulation and carry chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      idx_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else if (state_r == RUN) begin
      for (int n = 0; n < NIB; n++) begin
        if (idx_r == IW'(n)) begin
          sum_r[4*n +: 4] <= add_s;
        end
      end
      carry_r <= add_c4;
      // Wrap to zero on the last nibble so idx never exceeds NIB-1.
      idx_r   <= done_s ? '0 : idx_r + IW'(1);
      cout_r  <= done_s ? add_c4 : cout_r;
    end else begin
      carry_r <= carry_r;
    end
  end

`ifdef NIBBLE_ADD_OVERFLOW_EN
  logic ovf_r;

  // Signed overflow: like-signed operands whose result sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (accept_s || release_s) begin
      ovf_r <= 1'b0;
    end else if (done_s) begin
      ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_s[3] != a_r[WIDTH-1]);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq: directed cases plus randomized traffic
// against a transaction-level model (define NIBBLE_ADD_OVERFLOW_EN to also check ovf).
module tb_nibble_serial_add_seq;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             cin = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready, out_valid, cout, busy, add_c0, add_c4;
  logic [WIDTH-1:0] sum;
  logic [3:0]       add_a, add_b, add_s;
`ifdef NIBBLE_ADD_OVERFLOW_EN
  logic             ovf;
`endif

  nibble_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_s(add_s), .add_c4(add_c4),
`ifdef NIBBLE_ADD_OVERFLOW_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  // The external 4-bit ripple adder.
  assign {add_c4, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c0};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: one outstanding add, result due NIB edges after accept.
  logic             pend, m_rdy, m_cout, m_ovf;
  logic [WIDTH-1:0] m_sum;
  int               k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; m_rdy <= 1'b0; k <= 0;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (!pend) begin
      m_rdy <= 1'b1;
      if (m_rdy && in_valid) begin
        pend  <= 1'b1;
        m_rdy <= 1'b0;
        k     <= 0;
        {m_cout, m_sum} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        m_ovf <= ($signed(a) + $signed(b) + $signed({1'b0, cin})) > 32'sd32767 ||
                 ($signed(a) + $signed(b) + $signed({1'b0, cin})) < -32'sd32768;
      end
    end else if (k >= NIB) begin
      if (out_ready) begin
        pend  <= 1'b0;
        m_rdy <= 1'b1;
      end
    end else begin
      k <= k + 1;
    end
  end

  // Cycle compare of all DUT outputs against the model.
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("busy", busy, pend && (k < NIB));
    chk("out_valid", out_valid, pend && (k >= NIB));
    if (!pend || k >= NIB) begin
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
    end
    if (!(pend && k < NIB)) chk("adder_idle", {add_a, add_b, add_c0}, 32'd0);
`ifdef NIBBLE_ADD_OVERFLOW_EN
    chk("ovf", ovf, (pend && k >= NIB) ? m_ovf : 1'b0);
`endif
  end

  logic [3:0] c0_hist = 4'h0;
  always @(negedge clk) if (busy) c0_hist <= {c0_hist[2:0], add_c0};

  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic [15:0] es, input logic ec, input int stall, input bit garbage);
    int n;
    int lat;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (garbage) begin a = 16'hAAAA; b = 16'hAAAA; end
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, NIB);
    repeat (stall) begin
      @(negedge clk); #1;
      chk("held_sum", sum, es);
      chk("held_in_ready", in_ready, 32'd0);
    end
    chk("sum_lit", sum, es);
    chk("cout_lit", cout, ec);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {in_ready, out_valid, busy, cout, sum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rdy_after_reset", in_ready, 32'd1);

    do_add(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 0, 1'b0);
    chk("c0_sequence", c0_hist, 32'h7);
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1, 1'b0);
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, 1'b0);
    do_add(16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 10, 1'b1);

    // Reset in the middle of RUN discards the partial result.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", {out_valid, busy, in_ready, sum}, 32'd0);
    chk("midreset_adder", {add_a, add_b, add_c0}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    do_add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 2, 1'b0);

`ifdef NIBBLE_ADD_OVERFLOW_EN
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1, 1'b0);
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1, 1'b0);
`endif

    // Randomized traffic, including a reset pulse in the middle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      if (i == 300) rst_n = 1'b0;
      if (i == 303) rst_n = 1'b1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
